// File: rtl/mux_saidas_display.sv
// mux_saidas_display
//   Registered display-source selector for the coffee machine. Picks one of
//   NCH display-code channels by the controller state, blanks unmapped
//   states, and adds per-channel blinking that restarts on every state
//   change so a new message always opens in its visible half.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   sd_in        in   NCH*DW packed channel codes, channel k = sd_in[k*DW +: DW]
//   estado       in   SW-bit controller state, selects channel estado
//   blink_en     in   NCH per-channel blink enables
//   bits_display out  DW-bit registered display code
//   sel_valid    out  registered, 1 when estado < NCH
//   blink_phase  out  registered, 1 = visible half, 0 = blanked half
module mux_saidas_display #(
  parameter int            NCH       = 5,
  parameter int            SW        = 3,
  parameter int            DW        = 4,
  parameter logic [DW-1:0] BLANK     = {DW{1'b1}},
  parameter int            BLINK_DIV = 25000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NCH*DW-1:0]   sd_in,
  input  logic [SW-1:0]       estado,
  input  logic [NCH-1:0]      blink_en,
  output logic [DW-1:0]       bits_display,
  output logic                sel_valid,
  output logic                blink_phase
);

  // Comparison width wide enough to hold both estado and NCH itself, so
  // that NCH >= 2^SW makes every estado valid instead of wrapping.
  localparam int CLOG_NCH = $clog2(NCH) + 1;
  localparam int CMPW     = (SW > CLOG_NCH) ? SW : CLOG_NCH;
  localparam int CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [CMPW-1:0] NCH_CMP  = CMPW'(NCH);

  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            phase_s;
  logic [SW-1:0]   estado_prev_r;
  logic [CMPW-1:0] estado_ext_s;
  logic            valid_s;
  logic [DW-1:0]   chan_s;
  logic            blink_s;
  logic [DW-1:0]   display_s;

  // Blink counter / phase next state; a state change outranks a wrap.
  always_comb begin
    cnt_s   = cnt_r;
    phase_s = blink_phase;
    if (estado != estado_prev_r) begin
      cnt_s   = {CW{1'b0}};
      phase_s = 1'b1;
    end else if (cnt_r == CNT_LAST) begin
      cnt_s   = {CW{1'b0}};
      phase_s = ~blink_phase;
    end else begin
      cnt_s   = cnt_r + CW'(1);
      phase_s = blink_phase;
    end
  end

  // Channel select and display code; blanking uses the next-state phase so
  // bits_display and blink_phase change together.
  always_comb begin
    estado_ext_s = CMPW'(estado);
    valid_s      = (estado_ext_s < NCH_CMP);
    chan_s       = BLANK;
    blink_s      = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      chan_s  = (estado_ext_s == CMPW'(k)) ? sd_in[k*DW +: DW] : chan_s;
      blink_s = (estado_ext_s == CMPW'(k)) ? blink_en[k]       : blink_s;
    end
    if (!valid_s) begin
      display_s = BLANK;
    end else if (blink_s && !phase_s) begin
      display_s = BLANK;
    end else begin
      display_s = chan_s;
    end
  end

  // Output, counter and previous-state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      bits_display  <= BLANK;
      sel_valid     <= 1'b0;
      blink_phase   <= 1'b1;
      cnt_r         <= {CW{1'b0}};
      estado_prev_r <= {SW{1'b0}};
    end else begin
      bits_display  <= display_s;
      sel_valid     <= valid_s;
      blink_phase   <= phase_s;
      cnt_r         <= cnt_s;
      estado_prev_r <= estado;
    end
  end

endmodule

// File: tb/tb_mux_saidas_display.sv
module tb_mux_saidas_display;
  localparam int NCH  = 5;
  localparam int SW   = 3;
  localparam int DW   = 4;
  localparam int BDIV = 4;
  localparam logic [DW-1:0] BLANK = 4'hF;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH*DW-1:0] sd_in;
  logic [SW-1:0]     estado;
  logic [NCH-1:0]    blink_en;
  logic [DW-1:0]     bits_display;
  logic              sel_valid;
  logic              blink_phase;

  int vectors = 0;
  int errors  = 0;

  mux_saidas_display #(
    .NCH(NCH), .SW(SW), .DW(DW), .BLANK(BLANK), .BLINK_DIV(BDIV)
  ) dut (
    .clock(clock), .reset(reset), .sd_in(sd_in), .estado(estado),
    .blink_en(blink_en), .bits_display(bits_display),
    .sel_valid(sel_valid), .blink_phase(blink_phase)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  // Reference model: the blink phase is a pure function of how many edges
  // have passed since the last restart (reset or state change).
  int          m_n;
  logic [SW-1:0] m_prev;
  logic [DW-1:0] m_disp;
  logic        m_valid;
  logic        m_phase;
  logic        m_on = 1'b0;

  initial begin
    int e;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_n = 0; m_prev = '0; m_disp = BLANK; m_valid = 1'b0; m_phase = 1'b1; m_on = 1'b1;
      end else begin
        if (estado != m_prev) m_n = 0; else m_n = m_n + 1;
        m_prev  = estado;
        m_phase = ((m_n / BDIV) % 2) == 0;
        e       = int'(estado);
        m_valid = e < NCH;
        if (!m_valid) m_disp = BLANK;
        else if (blink_en[e] && !m_phase) m_disp = BLANK;
        else m_disp = sd_in[e*DW +: DW];
      end
      #1;
      if (m_on) begin
        chk("model_display", 32'(bits_display), 32'(m_disp));
        chk("model_valid",   32'(sel_valid),    32'(m_valid));
        chk("model_phase",   32'(blink_phase),  32'(m_phase));
      end
    end
  end

  initial begin
    logic [3:0]  sweep_exp [8];
    logic [7:0]  sweep_val;
    logic [15:0] pat16;
    logic [7:0]  pat8;
    logic [11:0] pat12;

    sweep_exp = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 4'hF, 4'hF};
    sweep_val = 8'b0001_1111;

    // reset held with arbitrary inputs
    reset = 1'b1; estado = 3'd2; sd_in = 20'h12345; blink_en = 5'b11111;
    repeat (3) tick();
    chk("reset_display", 32'(bits_display), 32'hF);
    chk("reset_valid",   32'(sel_valid),    32'h0);
    chk("reset_phase",   32'(blink_phase),  32'h1);

    // release, channel 0 = 2
    reset = 1'b0; estado = 3'd0; sd_in = 20'h54322; blink_en = 5'b00000;
    tick();
    chk("release_display", 32'(bits_display), 32'h2);

    // sweep estado 0..7
    sd_in = 20'h54321;
    for (int i = 0; i < 8; i++) begin
      estado = 3'(i);
      tick();
      chk("sweep_display", 32'(bits_display), 32'(sweep_exp[i]));
      chk("sweep_valid",   32'(sel_valid),    32'(sweep_val[i]));
    end

    // blink on channel 3: 4 visible, 4 blank, repeating
    estado = 3'd3; sd_in = 20'h57321; blink_en = 5'b01000;
    pat16 = 16'h0F0F;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("blink_display", 32'(bits_display), pat16[i] ? 32'h7 : 32'hF);
      chk("blink_phase",   32'(blink_phase),  32'(pat16[i]));
    end

    // restart during the blank half: switch to channel 1
    estado = 3'd1; sd_in = 20'h57391; blink_en = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("restart_display", 32'(bits_display), 32'h9);
      chk("restart_phase",   32'(blink_phase),  32'h1);
    end

    // change on the counter's last count: phase forced visible, not toggled
    estado = 3'd3;
    pat8 = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("wrapchg_display", 32'(bits_display), pat8[i] ? 32'h7 : 32'hF);
      chk("wrapchg_phase",   32'(blink_phase),  32'(pat8[i]));
    end

    // reset mid-blink
    reset = 1'b1;
    tick();
    chk("midreset_display", 32'(bits_display), 32'hF);
    chk("midreset_phase",   32'(blink_phase),  32'h1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("postreset_display", 32'(bits_display), pat8[i] ? 32'h7 : 32'hF);
    end

    // unmapped state with every blink enabled
    estado = 3'd6; blink_en = 5'b11111;
    pat12 = 12'hF0F;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("unmapped_display", 32'(bits_display), 32'hF);
      chk("unmapped_valid",   32'(sel_valid),    32'h0);
      chk("unmapped_phase",   32'(blink_phase),  32'(pat12[i]));
    end

    // sd_in and blink_en changes mid-phase do not restart the blink
    estado = 3'd2; blink_en = 5'b00100;
    tick();
    tick();
    sd_in = 20'h57A91;
    tick();
    chk("sdchg_display", 32'(bits_display), 32'hA);
    chk("sdchg_phase",   32'(blink_phase),  32'h1);
    tick();
    tick();
    chk("sdchg_off_display", 32'(bits_display), 32'hF);
    blink_en = 5'b00000;
    tick();
    chk("bendis_display", 32'(bits_display), 32'hA);
    chk("bendis_phase",   32'(blink_phase),  32'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
